// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer.
// Issues req/ack fetches at pc and advances pc on accepted, unstalled fetches.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  pc_sel,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        flush,
  output logic        addr_error
);

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            fetch_c;
  logic            accept_c;
  logic            update_c;
  logic            nonseq_c;
  logic            misalign_c;
  logic [PC_W-1:0] branch_tgt_c;
  logic [PC_W-1:0] next_pc_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (imem_ack) state_nxt = stall ? HOLD : FETCH;
      HOLD:    if (!stall) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: request, acceptance and pc-update strobes
  always_comb begin
    fetch_c  = 1'b0;
    accept_c = 1'b0;
    update_c = 1'b0;
    case (state)
      FETCH: begin
        fetch_c  = 1'b1;
        accept_c = imem_ack;
        update_c = imem_ack && !stall;
      end
      HOLD:    update_c = !stall;
      default: ;
    endcase
  end

  assign imem_req  = fetch_c;
  assign imem_addr = pc;
  assign pc_plus4  = pc + PC_W'(4);

  assign branch_tgt_c = pc_plus4 + (branch_offset << 2);

  // Candidate target select; nonseq marks any taken redirect
  always_comb begin
    next_pc_c  = pc_plus4;
    nonseq_c   = 1'b0;
    misalign_c = 1'b0;
    if (redirect_valid) begin
      case (pc_sel)
        2'b01: begin
          if (zero) begin
            next_pc_c = branch_tgt_c;
            nonseq_c  = 1'b1;
          end
        end
        2'b10: begin
          nonseq_c = 1'b1;
          if (jr_target[1:0] != 2'b00) begin
            next_pc_c  = EXC_VECTOR;
            misalign_c = 1'b1;
          end else begin
            next_pc_c = jr_target;
          end
        end
        2'b11: begin
          next_pc_c = {pc_plus4[31:28], jump_index, 2'b00};
          nonseq_c  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // PC register and single-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      flush       <= 1'b0;
      addr_error  <= 1'b0;
    end else begin
      instr_valid <= accept_c;
      flush       <= update_c && nonseq_c;
      addr_error  <= update_c && misalign_c;
      if (update_c) pc <= next_pc_c;
    end
  end

endmodule
